// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: frames of 55 A5 ADDR LEN payload CHK become
// LEN consecutive register writes starting at ADDR, with timeout and checksum abort.
module uart_cmd_parser #(
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Rx_Done,
  input  logic [7:0] Data,
  output logic       Wr_En,
  output logic [7:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       Frame_Ok,
  output logic       Frame_Err,
  output logic       Busy
);

  localparam int IDXW = $clog2(MAX_LEN + 1);
  localparam int BUFW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMRW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMRW-1:0] TMR_LAST  = TMRW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_WRITE
  } state_t;

  state_t          state;
  logic [7:0]      base_addr;
  logic [7:0]      sum;
  logic [IDXW-1:0] len;
  logic [IDXW-1:0] idx;
  logic [TMRW-1:0] tmr;
  logic [7:0]      buffer [MAX_LEN];

  // NOTE: every sequential assignment is non-blocking so all registers see
  // pre-edge values; mixing in blocking writes would make results order-dependent.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      base_addr <= '0;
      sum       <= '0;
      len       <= '0;
      idx       <= '0;
      tmr       <= '0;
      Wr_En     <= 1'b0;
      Wr_Addr   <= '0;
      Wr_Data   <= '0;
      Frame_Ok  <= 1'b0;
      Frame_Err <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Wr_En     <= 1'b0;
      Frame_Ok  <= 1'b0;
      Frame_Err <= 1'b0;

      case (state)
        S_IDLE: begin
          tmr <= '0;
          if (Rx_Done && Data == 8'h55) begin
            state <= S_HDR2;
            Busy  <= 1'b1;
          end
        end

        // First write was issued on the checksum edge; idx points at the next one.
        S_WRITE: begin
          tmr <= '0;
          if (idx < len) begin
            Wr_En    <= 1'b1;
            Wr_Addr  <= base_addr + 8'(idx);
            Wr_Data  <= buffer[idx[BUFW-1:0]];
            Frame_Ok <= (idx == len - 1'b1);
            idx      <= idx + 1'b1;
          end else begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end
        end

        default: begin
          if (Rx_Done) begin
            tmr <= '0;
            case (state)
              S_HDR2: begin
                if (Data == 8'hA5) begin
                  state <= S_ADDR;
                end else if (Data != 8'h55) begin
                  state <= S_IDLE;
                  Busy  <= 1'b0;
                end
              end
              S_ADDR: begin
                base_addr <= Data;
                sum       <= Data;
                state     <= S_LEN;
              end
              S_LEN: begin
                if (Data >= 8'd1 && Data <= MAX_LEN_B) begin
                  len   <= Data[IDXW-1:0];
                  sum   <= sum + Data;
                  idx   <= '0;
                  state <= S_PAYLOAD;
                end else begin
                  Frame_Err <= 1'b1;
                  state     <= S_IDLE;
                  Busy      <= 1'b0;
                end
              end
              S_PAYLOAD: begin
                sum <= sum + Data;
                idx <= idx + 1'b1;
                if (idx == len - 1'b1) state <= S_CHK;
              end
              S_CHK: begin
                if (Data == sum) begin
                  Wr_En    <= 1'b1;
                  Wr_Addr  <= base_addr;
                  Wr_Data  <= buffer[0];
                  Frame_Ok <= (len == IDXW'(1));
                  idx      <= IDXW'(1);
                  state    <= S_WRITE;
                end else begin
                  Frame_Err <= 1'b1;
                  state     <= S_IDLE;
                  Busy      <= 1'b0;
                end
              end
              default: ;
            endcase
          end else if (tmr == TMR_LAST) begin
            tmr       <= '0;
            Frame_Err <= 1'b1;
            state     <= S_IDLE;
            Busy      <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: the payload buffer is deliberately left out of reset; every entry is
  // written before it is read, so resetting it would only add reset fan-out.
  always_ff @(posedge Clk) begin
    if (state == S_PAYLOAD && Rx_Done) buffer[idx[BUFW-1:0]] <= Data;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table of complete frames plus hand-timed
// sequences for write latency, timeout boundary and mid-frame reset.
module tb_uart_cmd_parser;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Rx_Done;
  logic [7:0] Data;
  logic       Wr_En;
  logic [7:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic       Frame_Ok;
  logic       Frame_Err;
  logic       Busy;

  uart_cmd_parser #(.MAX_LEN(8), .TIMEOUT_CYC(100)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Rx_Done(Rx_Done), .Data(Data),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Frame_Ok(Frame_Ok), .Frame_Err(Frame_Err), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Cumulative monitor; tests work on deltas so only this block writes these.
  int         mon_nw = 0, mon_ok = 0, mon_err = 0, mon_both = 0;
  logic [7:0] mon_a [256];
  logic [7:0] mon_d [256];

  always @(negedge Clk) begin
    if (Wr_En === 1'b1) begin
      mon_a[mon_nw % 256] = Wr_Addr;
      mon_d[mon_nw % 256] = Wr_Data;
      mon_nw++;
    end
    if (Frame_Ok === 1'b1) mon_ok++;
    if (Frame_Err === 1'b1) mon_err++;
    if (Frame_Ok === 1'b1 && Frame_Err === 1'b1) mon_both++;
  end

  typedef struct {
    string              name;
    int                 n;
    logic [0:13][7:0]   b;
    int                 nw;
    logic [0:7][7:0]    wa;
    logic [0:7][7:0]    wd;
    int                 ok;
    int                 err;
  } vec_t;

  vec_t vecs [9];
  int   base_w, base_ok, base_err;

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    Rx_Done = 1'b1;
    Data    = b;
    @(negedge Clk);
    Rx_Done = 1'b0;
    Data    = 8'h00;
    @(negedge Clk);
  endtask

  task automatic snap();
    base_w   = mon_nw;
    base_ok  = mon_ok;
    base_err = mon_err;
  endtask

  task automatic check_write(input string name, input int k,
                             input logic [7:0] ea, input logic [7:0] ed);
    check({name, "_addr"}, 32'(mon_a[(base_w + k) % 256]), 32'(ea));
    check({name, "_data"}, 32'(mon_d[(base_w + k) % 256]), 32'(ed));
  endtask

  initial begin
    int got;

    vecs[0] = '{"nominal", 7, {8'h55,8'hA5,8'h10,8'h02,8'hAB,8'hCD,8'h8A,{7{8'h00}}},
                2, {8'h10,8'h11,{6{8'h00}}}, {8'hAB,8'hCD,{6{8'h00}}}, 1, 0};
    vecs[1] = '{"bad_chk", 7, {8'h55,8'hA5,8'h10,8'h02,8'hAB,8'hCD,8'h8B,{7{8'h00}}},
                0, {8{8'h00}}, {8{8'h00}}, 0, 1};
    vecs[2] = '{"len_zero", 4, {8'h55,8'hA5,8'h10,8'h00,{10{8'h00}}},
                0, {8{8'h00}}, {8{8'h00}}, 0, 1};
    vecs[3] = '{"len_over", 4, {8'h55,8'hA5,8'h10,8'h09,{10{8'h00}}},
                0, {8{8'h00}}, {8{8'h00}}, 0, 1};
    vecs[4] = '{"addr_wrap", 7, {8'h55,8'hA5,8'hFF,8'h02,8'h01,8'h02,8'h04,{7{8'h00}}},
                2, {8'hFF,8'h00,{6{8'h00}}}, {8'h01,8'h02,{6{8'h00}}}, 1, 0};
    // 0x10 + 0x01 + 0x7F = 0x90
    vecs[5] = '{"resync", 7, {8'h55,8'h55,8'hA5,8'h10,8'h01,8'h7F,8'h90,{7{8'h00}}},
                1, {8'h10,{7{8'h00}}}, {8'h7F,{7{8'h00}}}, 1, 0};
    vecs[6] = '{"max_len", 13, {8'h55,8'hA5,8'h20,8'h08,8'h01,8'h02,8'h03,8'h04,
                                8'h05,8'h06,8'h07,8'h08,8'h4C,8'h00},
                8, {8'h20,8'h21,8'h22,8'h23,8'h24,8'h25,8'h26,8'h27},
                {8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08}, 1, 0};
    vecs[7] = '{"hdr_abort", 7, {8'h55,8'h12,8'hA5,8'h10,8'h01,8'h7F,8'h90,{7{8'h00}}},
                0, {8{8'h00}}, {8{8'h00}}, 0, 0};
    vecs[8] = '{"garbage_first", 9, {8'h00,8'hFF,8'hA5,8'h55,8'hA5,8'h30,8'h01,8'h00,8'h31,{5{8'h00}}},
                1, {8'h30,{7{8'h00}}}, {8'h00,{7{8'h00}}}, 1, 0};

    Reset_n = 1'b0;
    Rx_Done = 1'b0;
    Data    = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_wr_en",   32'(Wr_En),     32'h0);
    check("rst_wr_addr", 32'(Wr_Addr),   32'h0);
    check("rst_wr_data", 32'(Wr_Data),   32'h0);
    check("rst_ok",      32'(Frame_Ok),  32'h0);
    check("rst_err",     32'(Frame_Err), 32'h0);
    check("rst_busy",    32'(Busy),      32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      snap();
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
      repeat (20) @(negedge Clk);
      check({vecs[i].name, "_nwrites"}, 32'(mon_nw - base_w), 32'(vecs[i].nw));
      for (int k = 0; k < vecs[i].nw; k++)
        check_write(vecs[i].name, k, vecs[i].wa[k], vecs[i].wd[k]);
      check({vecs[i].name, "_ok"},   32'(mon_ok - base_ok),   32'(vecs[i].ok));
      check({vecs[i].name, "_err"},  32'(mon_err - base_err), 32'(vecs[i].err));
      check({vecs[i].name, "_busy"}, 32'(Busy), 32'h0);
    end

    // Write latency and a byte dropped while writing.
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h10);
    send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
    @(negedge Clk);
    Rx_Done = 1'b1;
    Data    = 8'h8A;
    @(posedge Clk); #1;
    Data = 8'h55;
    check("lat_w0_en",   32'(Wr_En),    32'h1);
    check("lat_w0_addr", 32'(Wr_Addr),  32'h10);
    check("lat_w0_data", 32'(Wr_Data),  32'hAB);
    check("lat_w0_ok",   32'(Frame_Ok), 32'h0);
    check("lat_w0_busy", 32'(Busy),     32'h1);
    @(posedge Clk); #1;
    Rx_Done = 1'b0;
    check("lat_w1_en",   32'(Wr_En),     32'h1);
    check("lat_w1_addr", 32'(Wr_Addr),   32'h11);
    check("lat_w1_data", 32'(Wr_Data),   32'hCD);
    check("lat_w1_ok",   32'(Frame_Ok),  32'h1);
    check("lat_w1_err",  32'(Frame_Err), 32'h0);
    @(posedge Clk); #1;
    check("lat_end_en",  32'(Wr_En), 32'h0);
    check("lat_end_ok",  32'(Frame_Ok), 32'h0);
    repeat (3) @(posedge Clk); #1;
    check("lat_drop_busy", 32'(Busy), 32'h0);

    // Stall after ADDR: error exactly TIMEOUT_CYC edges after the last byte.
    snap();
    send_byte(8'h55); send_byte(8'hA5);
    @(negedge Clk);
    Rx_Done = 1'b1;
    Data    = 8'h10;
    @(posedge Clk); #1;
    Rx_Done = 1'b0;
    got = 0;
    for (int k = 1; k <= 150 && got == 0; k++) begin
      @(posedge Clk); #1;
      if (Frame_Err === 1'b1) got = k;
    end
    check("timeout_cycles", 32'(got), 32'd100);
    @(posedge Clk); #1;
    check("timeout_busy", 32'(Busy), 32'h0);
    check("timeout_err_count", 32'(mon_err - base_err), 32'h1);

    // Byte landing on the timeout edge wins; the frame completes.
    snap();
    send_byte(8'h55); send_byte(8'hA5);
    @(negedge Clk);
    Rx_Done = 1'b1;
    Data    = 8'h10;
    @(posedge Clk); #1;
    Rx_Done = 1'b0;
    repeat (99) @(posedge Clk);
    #1;
    Rx_Done = 1'b1;
    Data    = 8'h01;
    @(posedge Clk); #1;
    Rx_Done = 1'b0;
    check("tie_no_err",  32'(Frame_Err), 32'h0);
    check("tie_busy",    32'(Busy),      32'h1);
    send_byte(8'h7F); send_byte(8'h90);
    repeat (10) @(negedge Clk);
    check("tie_nwrites", 32'(mon_nw - base_w), 32'h1);
    check_write("tie", 0, 8'h10, 8'h7F);
    check("tie_ok",  32'(mon_ok - base_ok),   32'h1);
    check("tie_err", 32'(mon_err - base_err), 32'h0);

    // Reset during PAYLOAD abandons the frame silently.
    snap();
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h10);
    send_byte(8'h02); send_byte(8'hAB);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("rstp_busy", 32'(Busy), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    send_byte(8'hCD); send_byte(8'h8A);
    repeat (10) @(negedge Clk);
    check("rstp_nwrites", 32'(mon_nw - base_w),   32'h0);
    check("rstp_err",     32'(mon_err - base_err), 32'h0);
    check("rstp_ok",      32'(mon_ok - base_ok),   32'h0);

    // Reset during WRITE cuts the burst after two writes.
    snap();
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h20); send_byte(8'h08);
    for (int k = 1; k <= 8; k++) send_byte(8'(k));
    @(negedge Clk);
    Rx_Done = 1'b1;
    Data    = 8'h4C;
    @(posedge Clk); #1;
    Rx_Done = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    check("rstw_wr_en", 32'(Wr_En), 32'h0);
    check("rstw_busy",  32'(Busy),  32'h0);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    check("rstw_nwrites", 32'(mon_nw - base_w),   32'h2);
    check("rstw_ok",      32'(mon_ok - base_ok),   32'h0);
    check("rstw_err",     32'(mon_err - base_err), 32'h0);

    check("ok_err_overlap", 32'(mon_both), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
